// File: rtl/nand_reduce_pipe.sv
// Pipelined per-channel wide NAND built from registered FANIN-input AND levels.
// Optional define NAND_REDUCE_MODE_EN adds a MODE input (NAND/AND/NOR/OR).
module nand_reduce_pipe #(
   parameter int NUM_IN = 9,
   parameter int NUM_CH = 2,
   parameter int FANIN  = 3
) (
   input  logic                     CLK,
   input  logic                     R,
   input  logic                     EN,
   input  logic                     VI,
`ifdef NAND_REDUCE_MODE_EN
   input  logic [1:0]               MODE,
`endif
   input  logic [NUM_CH*NUM_IN-1:0] A,
   output logic [NUM_CH-1:0]        Y,
   output logic                     VO
);

   function automatic int lvl_w(input int k);
      int w;
      w = NUM_IN;
      for (int i = 0; i < k; i++) w = (w + FANIN - 1) / FANIN;
      return w;
   endfunction

   function automatic int calc_lat();
      int w;
      int l;
      w = NUM_IN;
      l = 0;
      for (int i = 0; i < 32; i++) begin
         if (w > 1) begin
            w = (w + FANIN - 1) / FANIN;
            l++;
         end
      end
      return (l < 1) ? 1 : l;
   endfunction

   localparam int LAT = calc_lat();

   for (genvar k = 1; k <= LAT; k++) begin : g_lvl
      localparam int WI   = lvl_w(k - 1);
      localparam int WO   = lvl_w(k);
      localparam bit LAST = (k == LAT);

      wire  [NUM_CH-1:0][WI-1:0] src;
      wire  [NUM_CH-1:0][WO-1:0] nxt;
      wire                       vin;
      logic [NUM_CH-1:0][WO-1:0] q;
      logic                      v;
`ifdef NAND_REDUCE_MODE_EN
      wire  [1:0]                md;
`endif

      if (k == 1) begin : g_src
         for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign src[c] = A[c*NUM_IN +: NUM_IN];
         end
         assign vin = VI;
`ifdef NAND_REDUCE_MODE_EN
         assign md = MODE;
`endif
      end else begin : g_src
         assign src = g_lvl[k-1].q;
         assign vin = g_lvl[k-1].v;
`ifdef NAND_REDUCE_MODE_EN
         assign md = g_lvl[k-1].g_mreg.mq;
`endif
      end

      // Short last node needs no explicit padding: a narrower reduction is the identity pad.
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         for (genvar n = 0; n < WO; n++) begin : g_node
            localparam int LO  = n * FANIN;
            localparam int CNT = (WI - LO < FANIN) ? (WI - LO) : FANIN;
`ifdef NAND_REDUCE_MODE_EN
            assign nxt[c][n] =
               (md[1] ? (|src[c][LO +: CNT]) : (&src[c][LO +: CNT]))
               ^ (LAST && !md[0]);
`else
            assign nxt[c][n] = (&src[c][LO +: CNT]) ^ LAST;
`endif
         end
      end

      always_ff @(posedge CLK or negedge R) begin
         if (!R) begin
            q <= {(NUM_CH*WO){LAST}};
            v <= 1'b0;
         end else if (EN) begin
            q <= nxt;
            v <= vin;
         end
      end

`ifdef NAND_REDUCE_MODE_EN
      if (!LAST) begin : g_mreg
         logic [1:0] mq;
         always_ff @(posedge CLK or negedge R) begin
            if (!R) mq <= 2'b00;
            else if (EN) mq <= md;
         end
      end
`endif
   end

   assign Y  = g_lvl[LAT].q;
   assign VO = g_lvl[LAT].v;

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Directed bench for nand_reduce_pipe at default sizing (9 inputs, 2 channels, LAT=2).
// Mode vectors run when NAND_REDUCE_MODE_EN is defined.
module tb_nand_reduce_pipe;

   logic        CLK = 1'b0;
   logic        R;
   logic        EN;
   logic        VI;
   logic [17:0] A;
   logic [1:0]  Y;
   logic        VO;
`ifdef NAND_REDUCE_MODE_EN
   logic [1:0]  MODE;
`endif

   int checks = 0;
   int errors = 0;

   nand_reduce_pipe dut (
      .CLK(CLK),
      .R(R),
      .EN(EN),
      .VI(VI),
`ifdef NAND_REDUCE_MODE_EN
      .MODE(MODE),
`endif
      .A(A),
      .Y(Y),
      .VO(VO)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [17:0] a;
      logic [1:0]  y;
   } vec_t;

   vec_t tbl[8];

   logic       m1v, m2v;
   logic [1:0] m1y, m2y;
   int         vo_cnt;
   int         issued;

   function automatic logic [1:0] nref(input logic [17:0] a);
      return {~&a[17:9], ~&a[8:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Reference pipeline of depth 2, advancing only on enabled edges.
   task automatic mtick;
      @(posedge CLK);
      if (EN) begin
         m2v = m1v;
         m2y = m1y;
         m1v = VI;
         m1y = nref(A);
      end
      #1;
      chk("stream_vo", 32'(VO), 32'(m2v));
      if (m2v) chk("stream_y", 32'(Y), 32'(m2y));
      if (EN && VO) vo_cnt++;
   endtask

   initial begin
      tbl[0] = '{18'h3FFFF, 2'b00};
      tbl[1] = '{18'h3FDFF, 2'b10};
      tbl[2] = '{18'h00000, 2'b11};
      tbl[3] = '{18'h3FE00, 2'b01};
      tbl[4] = '{18'h3FFFE, 2'b01};
      tbl[5] = '{18'h2FFFF, 2'b10};
      tbl[6] = '{18'h3FFBF, 2'b01};
      tbl[7] = '{18'h15555, 2'b11};

      R  = 1'b1;
      EN = 1'b1;
      VI = 1'b0;
      A  = '0;
`ifdef NAND_REDUCE_MODE_EN
      MODE = 2'b00;
`endif
      #1 R = 1'b0;
      #1;
      chk("reset_vo", 32'(VO), 32'd0);
      chk("reset_y", 32'(Y), 32'h3);

      for (int i = 0; i < 5; i++) begin
         A  = 18'($urandom);
         VI = 1'($urandom);
         tick();
         chk("reset_hold_vo", 32'(VO), 32'd0);
         chk("reset_hold_y", 32'(Y), 32'h3);
      end

      R  = 1'b1;
      A  = 18'h3FFFF;
      VI = 1'b1;
      tick();
      chk("release_vo_edge1", 32'(VO), 32'd0);
      A  = 18'h3FDFF;
      tick();
      chk("release_vo_edge2", 32'(VO), 32'd1);
      chk("func_all_ones", 32'(Y), 32'h0);
      VI = 1'b0;
      tick();
      chk("func_ch1_low_vo", 32'(VO), 32'd1);
      chk("func_ch1_low", 32'(Y), 32'h2);
      tick();
      chk("idle_vo", 32'(VO), 32'd0);

      for (int i = 0; i < 8; i++) begin
         A  = tbl[i].a;
         VI = 1'b1;
         tick();
         if (i > 0) begin
            chk($sformatf("tbl_y%0d", i - 1), 32'(Y), 32'(tbl[i-1].y));
            chk($sformatf("tbl_vo%0d", i - 1), 32'(VO), 32'd1);
         end
      end
      VI = 1'b0;
      tick();
      chk("tbl_y7", 32'(Y), 32'(tbl[7].y));
      tick();
      chk("tbl_drain_vo", 32'(VO), 32'd0);

      m1v = 1'b0;
      m2v = 1'b0;
      m1y = 2'b11;
      m2y = 2'b11;
      vo_cnt = 0;
      issued = 0;
      for (int i = 0; i < 40 && issued < 20; i++) begin
         EN = !(i >= 8 && i < 11);
         A  = 18'($urandom);
         VI = EN ? 1'b1 : 1'($urandom);
         if (EN) issued++;
         mtick();
      end
      EN = 1'b1;
      VI = 1'b0;
      mtick();
      mtick();
      mtick();
      chk("stream_count", 32'(vo_cnt), 32'd20);

      A  = 18'h3FFFF;
      VI = 1'b1;
      tick();
      A  = 18'h00000;
      tick();
      chk("midrst_pre_vo", 32'(VO), 32'd1);
      #3 R = 1'b0;
      #1;
      chk("midrst_async_vo", 32'(VO), 32'd0);
      chk("midrst_async_y", 32'(Y), 32'h3);
      VI = 1'b0;
      tick();
      chk("midrst_low_vo", 32'(VO), 32'd0);
      R = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst_no_stale_vo", 32'(VO), 32'd0);
      end
      A  = 18'h3FDFF;
      VI = 1'b1;
      tick();
      chk("midrst_new_edge1_vo", 32'(VO), 32'd0);
      VI = 1'b0;
      tick();
      chk("midrst_new_vo", 32'(VO), 32'd1);
      chk("midrst_new_y", 32'(Y), 32'h2);

      A  = 'x;
      VI = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("x_in_vo", 32'(VO), 32'd0);
      end
      A = '0;

`ifdef NAND_REDUCE_MODE_EN
      VI   = 1'b1;
      A    = 18'h00000;
      MODE = 2'b10;
      tick();
      MODE = 2'b11;
      tick();
      chk("mode_nor", 32'(Y), 32'h3);
      A    = 18'h3FFFF;
      MODE = 2'b01;
      tick();
      chk("mode_or", 32'(Y), 32'h0);
      VI   = 1'b0;
      MODE = 2'b00;
      tick();
      chk("mode_and", 32'(Y), 32'h3);
      chk("mode_and_vo", 32'(VO), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nand_reduce_pipe.md
Name: nand_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-input NAND cell.
- Computes, for each of NUM_CH independent channels, the NAND of NUM_IN inputs.
- Uses a registered reduction tree of FANIN-input AND levels; the final level inverts.
- A valid bit travels alongside the data, and a global enable stalls the whole pipeline.
- Used as a wide-decode / match-detect primitive in synthesized datapaths where a flat wide NAND would break timing.

Parameters:
- NUM_IN, 9: inputs reduced per channel (>=1).
- NUM_CH, 2: independent channels (>=1).
- FANIN, 3: max inputs per AND node per level (2..4).
- LAT (derived localparam, not overridable): ceil(log_FANIN(NUM_IN)), minimum 1. Number of register stages.

Ports:
- CLK, input, 1: rising-edge clock.
- R, input, 1: asynchronous active-low reset.
- EN, input, 1: pipeline advance enable.
- VI, input, 1: input data valid.
- A, input, NUM_CH*NUM_IN: channel c occupies A[c*NUM_IN +: NUM_IN].
- Y, output, NUM_CH: Y[c] = NAND of channel c's inputs, LAT cycles after sampling.
- VO, output, 1: Y valid.

Behaviour:
- Reset: R low clears all valid bits immediately and asynchronously, so VO=0. All intermediate partial-AND registers reset to 0. Y resets to all ones.
- Release of R is synchronous in effect: the first capture is on the first rising CLK edge with R high.
- Level k groups level k-1 terms into nodes of at most FANIN inputs, taken in index order; the last node takes the remainder.
  - Padding is logic 1 (AND identity).
  - Each level's results are registered.
  - The last level's output is inverted before its register (Y).
- NUM_IN=1: LAT=1, Y[c] = ~A[c] registered.
- Latency: A/VI sampled at edge n with EN=1 produce Y/VO at edge n+LAT-1 (visible after it), provided EN stays 1.
- EN=0: every stage register (data and valid) holds. Y and VO hold. A and VI are ignored.
- Data registers load whenever EN=1, regardless of VI.
  - VO only qualifies Y.
  - Y while VO=0 is don't-care for checkers, except immediately after reset, where it is all ones.
- Throughput: one result per enabled cycle, with no bubbles.
- Channels never interact. No combinational path from any input to any output.
- Reset asserted mid-stream:
  - In-flight valids are discarded; VO=0 within the same cycle (asynchronous).
  - No stale result emerges after release.
- X on A with VI=0 must not propagate into VO.

Optional Feature:
- Macro: NAND_REDUCE_MODE_EN.
- Defined:
  - Adds input MODE, 2 bits, sampled with A when EN=1 and carried down the pipeline with the data.
  - Function per MODE: 00 NAND, 01 AND, 10 NOR, 11 OR.
  - NOR/OR use an OR tree, padded with 0. Final inversion is applied for MODE 00 and 10 only.
  - Y reset value: all ones. MODE pipeline registers reset to 00.
- Undefined:
  - No MODE port. NAND only. Behaviour exactly as above.

Test Plan:
All scenarios use defaults: NUM_IN=9, NUM_CH=2, FANIN=3, LAT=2.
- Reset: R=0 with EN=1 and random A/VI for 5 cycles -> VO=0 and Y=2'b11 throughout. First result appears 2 edges after R rises, with VI=1 at the first edge.
- Function: A=18'h3FFFF, VI=1 -> Y=2'b00, VO=1 at edge+1. Next, A=18'h3FDFF (ch1 bit0 low) -> Y=2'b10.
- Streaming: 20 back-to-back random vectors with VI=1 and EN=1 -> 20 consecutive VO=1 cycles. Y matches the reference NAND per channel, each delayed by 2 cycles.
- Stall: EN=0 for 3 cycles mid-stream -> Y and VO frozen. After EN=1, the stream resumes with no loss or duplication.
- Reset mid-flight: drive R low one cycle after VI=1 -> VO=0 asynchronously. No VO=1 appears after release until new VI=1 input has travelled LAT cycles.
- Mode (with NAND_REDUCE_MODE_EN): A=18'h0, MODE=10 -> Y=2'b11. MODE=11 -> Y=2'b00. MODE=01 with A=18'h3FFFF -> Y=2'b11.
